uart_cmd_ctrl: RTL and testbench

Command-framing controller that sits directly behind the UART receiver. It consumes received bytes via the rx_rdy/rx_rdy_clr handshake and assembles NUM_BYTES consecutive bytes into one command word. It presents the command to the downstream command processor with a level cmd_rdy flag. An inter-byte timeout discards partial frames, and an overrun flag reports unconsumed commands that were overwritten.

---
 rtl/uart_cmd_ctrl.sv | 159 +++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - UART byte-to-command framing controller (optional checksum via UART_CMD_CKSUM_EN)
module uart_cmd_ctrl #(
    parameter int NUM_BYTES  = 3,
    parameter int TMO_CYCLES = 50000,
    parameter int TMO_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_rdy,
    input  logic [7:0]             rx_data,
    output logic                   rx_rdy_clr,
    output logic [8*NUM_BYTES-1:0] cmd,
    output logic                   cmd_rdy,
    input  logic                   clr_cmd_rdy,
    output logic                   cmd_ovr,
    output logic                   tmo,
    output logic                   cksum_err
);

`ifdef UART_CMD_CKSUM_EN
    // One trailing checksum byte follows the payload.
    localparam int FRAME_LEN = NUM_BYTES + 1;
`else
    localparam int FRAME_LEN = NUM_BYTES;
`endif
    localparam int CMD_W = 8 * NUM_BYTES;
    localparam int CNT_W = $clog2(FRAME_LEN + 2);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TMO_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACK     = 2'd1,
        COLLECT = 2'd2
    } state_t;

    state_t             state_q;
    logic [CMD_W-1:0]   asm_q;
    logic [CNT_W-1:0]   byte_cnt_q;
    logic [TMO_W-1:0]   tmo_cnt_q;
    logic [CMD_W-1:0]   cmd_q;
    logic               cmd_rdy_q;
    logic               cmd_ovr_q;
    logic               rx_rdy_clr_q;
    logic               tmo_q;

    logic [CMD_W-1:0]   asm_d;
    logic [CNT_W-1:0]   byte_cnt_d;
    logic               payload_byte;
    logic               frame_ok;

    assign asm_d      = {asm_q[CMD_W-9:0], rx_data};
    assign byte_cnt_d = byte_cnt_q + CNT_W'(1);

`ifdef UART_CMD_CKSUM_EN
    localparam logic [CNT_W-1:0] PAYLOAD_LEN = CNT_W'(NUM_BYTES);
    logic [7:0] sum_q;
    logic       cksum_err_q;

    // The checksum byte is counted and summed but never shifted into the command.
    assign payload_byte = (byte_cnt_q < PAYLOAD_LEN);
    // Payload sum plus checksum byte must come to all ones.
    assign frame_ok     = (sum_q == 8'hFF);
    assign cksum_err    = cksum_err_q;
`else
    assign payload_byte = 1'b1;
    assign frame_ok     = 1'b1;
    assign cksum_err    = 1'b0;
`endif

    // Framing FSM: capture, acknowledge, complete or time out a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            asm_q        <= '0;
            byte_cnt_q   <= '0;
            tmo_cnt_q    <= '0;
            cmd_q        <= '0;
            cmd_rdy_q    <= 1'b0;
            cmd_ovr_q    <= 1'b0;
            rx_rdy_clr_q <= 1'b0;
            tmo_q        <= 1'b0;
`ifdef UART_CMD_CKSUM_EN
            sum_q        <= '0;
            cksum_err_q  <= 1'b0;
`endif
        end else begin
            rx_rdy_clr_q <= 1'b0;
            tmo_q        <= 1'b0;
`ifdef UART_CMD_CKSUM_EN
            cksum_err_q  <= 1'b0;
`endif
            // Consumer acknowledge; a completion later in this block overrides it.
            if (clr_cmd_rdy) begin
                cmd_rdy_q <= 1'b0;
                cmd_ovr_q <= 1'b0;
            end
            case (state_q)
                IDLE, COLLECT: begin
                    if (rx_rdy) begin
                        if (payload_byte) begin
                            asm_q <= asm_d;
                        end
`ifdef UART_CMD_CKSUM_EN
                        sum_q <= sum_q + rx_data;
`endif
                        byte_cnt_q   <= byte_cnt_d;
                        tmo_cnt_q    <= '0;
                        rx_rdy_clr_q <= 1'b1;
                        state_q      <= ACK;
                    end else if (state_q == COLLECT) begin
                        if (tmo_cnt_q == TMO_LAST) begin
                            // Stale partial frame: drop it without touching cmd.
                            tmo_q      <= 1'b1;
                            asm_q      <= '0;
                            byte_cnt_q <= '0;
                            tmo_cnt_q  <= '0;
`ifdef UART_CMD_CKSUM_EN
                            sum_q      <= '0;
`endif
                            state_q    <= IDLE;
                        end else begin
                            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                        end
                    end
                end
                ACK: begin
                    if (byte_cnt_q == FRAME_LAST) begin
                        byte_cnt_q <= '0;
`ifdef UART_CMD_CKSUM_EN
                        sum_q      <= '0;
`endif
                        state_q    <= IDLE;
                        if (frame_ok) begin
                            cmd_q     <= asm_q;
                            cmd_rdy_q <= 1'b1;
                            // Overrun only if the old command was neither consumed nor being consumed now.
                            cmd_ovr_q <= ~clr_cmd_rdy & (cmd_ovr_q | cmd_rdy_q);
                        end else begin
`ifdef UART_CMD_CKSUM_EN
                            cksum_err_q <= 1'b1;
`endif
                        end
                    end else begin
                        state_q <= COLLECT;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_rdy_clr = rx_rdy_clr_q;
    assign cmd        = cmd_q;
    assign cmd_rdy    = cmd_rdy_q;
    assign cmd_ovr    = cmd_ovr_q;
    assign tmo        = tmo_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - self-checking bench for uart_cmd_ctrl
module tb_uart_cmd_ctrl;
    localparam int NB  = 3;
    localparam int TMO = 20;
    localparam int TW  = 5;
`ifdef UART_CMD_CKSUM_EN
    localparam int FL = NB + 1;
`else
    localparam int FL = NB;
`endif

    logic        clk;
    logic        rst;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        rx_rdy_clr;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        cmd_ovr;
    logic        tmo;
    logic        cksum_err;

    uart_cmd_ctrl #(
        .NUM_BYTES (NB),
        .TMO_CYCLES(TMO),
        .TMO_W     (TW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data),
        .rx_rdy_clr (rx_rdy_clr),
        .cmd        (cmd),
        .cmd_rdy    (cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .cmd_ovr    (cmd_ovr),
        .tmo        (tmo),
        .cksum_err  (cksum_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int clr_seen = 0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, output int waited);
        rx_data = b;
        rx_rdy  = 1'b1;
        waited  = 0;
        do begin
            step();
            waited++;
        end while (!rx_rdy_clr && waited < 10);
        check("rx_rdy_clr_seen", {63'd0, rx_rdy_clr}, 64'd1);
        if (rx_rdy_clr) clr_seen++;
        rx_rdy = 1'b0;
    endtask

    function automatic logic [7:0] cks3(input logic [23:0] v);
        logic [7:0] s;
        s = v[23:16] + v[15:8] + v[7:0];
        return ~s;
    endfunction

    task automatic send_frame3(input logic [23:0] v);
        int w;
        send_byte(v[23:16], w);
        send_byte(v[15:8], w);
        send_byte(v[7:0], w);
`ifdef UART_CMD_CKSUM_EN
        send_byte(cks3(v), w);
`endif
    endtask

    task automatic check_out(input string tag, input logic [23:0] c, input logic r, input logic o);
        check({tag, "_cmd"}, {40'd0, cmd}, {40'd0, c});
        check({tag, "_rdy"}, {63'd0, cmd_rdy}, {63'd0, r});
        check({tag, "_ovr"}, {63'd0, cmd_ovr}, {63'd0, o});
    endtask

    task automatic pulse_clr();
        clr_cmd_rdy = 1'b1;
        step();
        clr_cmd_rdy = 1'b0;
    endtask

    // Reference model state: bytes of the frame in progress and expected outputs.
    logic [7:0]  fq[$];
    logic [23:0] m_cmd;
    logic        m_rdy;
    logic        m_ovr;
    logic        m_cerr;

    task automatic model_byte(input logic [7:0] b);
        logic [23:0] val;
        logic [7:0]  sum;
        logic        ok;
        m_cerr = 1'b0;
        fq.push_back(b);
        if (fq.size() == FL) begin
            val = '0;
            sum = '0;
            for (int i = 0; i < FL; i++) begin
                if (i < NB) val = {val[15:0], fq[i]};
                sum = sum + fq[i];
            end
`ifdef UART_CMD_CKSUM_EN
            ok = (sum == 8'hFF);
`else
            ok = 1'b1;
`endif
            if (ok) begin
                m_ovr = m_ovr | m_rdy;
                m_cmd = val;
                m_rdy = 1'b1;
            end else begin
                m_cerr = 1'b1;
            end
            fq.delete();
        end
    endtask

    initial begin
        int w;
        int cnt;
        int first;
        int g;
        int tmo_cnt;
        logic [7:0] b;
        logic [7:0] s;
        int gaps[9] = '{1, 2, 3, 5, 19, 20, 21, 22, 30};

        rst = 1'b1; rx_rdy = 1'b0; rx_data = '0; clr_cmd_rdy = 1'b0;
        step(); step();
        check_out("reset", 24'h0, 1'b0, 1'b0);
        check("reset_clr", {63'd0, rx_rdy_clr}, 64'd0);
        check("reset_tmo", {63'd0, tmo}, 64'd0);
        check("reset_cerr", {63'd0, cksum_err}, 64'd0);
        rst = 1'b0;
        step();

        // Basic frame, bytes sent back to back.
        clr_seen = 0;
        send_byte(8'hA5, w);
        check("t1_lat_b0", w, 1);
        send_byte(8'h12, w);
        check("t1_lat_b1", w, 2);
        send_byte(8'h34, w);
        check("t1_lat_b2", w, 2);
`ifdef UART_CMD_CKSUM_EN
        send_byte(cks3(24'hA51234), w);
        check("t1_lat_ck", w, 2);
`endif
        check("t1_rdy_early", {63'd0, cmd_rdy}, 64'd0);
        step();
        check("t1_pulses", clr_seen, FL);
        check("t1_clr_low", {63'd0, rx_rdy_clr}, 64'd0);
        check_out("t1", 24'hA51234, 1'b1, 1'b0);
        check("t1_tmo", {63'd0, tmo}, 64'd0);
        pulse_clr();

        // rx_rdy held high across the ACK edge must capture once.
        rx_data = 8'h55; rx_rdy = 1'b1;
        cnt = 0;
        step(); cnt += int'(rx_rdy_clr);
        step(); cnt += int'(rx_rdy_clr);
        rx_rdy = 1'b0;
        step(); cnt += int'(rx_rdy_clr);
        step(); cnt += int'(rx_rdy_clr);
        check("t2_one_ack", cnt, 1);
        send_byte(8'h66, w);
        step();
        check("t2_rdy_mid", {63'd0, cmd_rdy}, 64'd0);
        send_byte(8'h77, w);
`ifdef UART_CMD_CKSUM_EN
        send_byte(cks3(24'h556677), w);
`endif
        step();
        check_out("t2", 24'h556677, 1'b1, 1'b0);
        pulse_clr();

        // Inter-byte timeout discards the partial frame.
        send_byte(8'h01, w);
        first = 0; cnt = 0;
        for (int k = 1; k <= 23; k++) begin
            step();
            if (tmo) begin
                cnt++;
                if (first == 0) first = k;
            end
        end
        check("t3_tmo_count", cnt, 1);
        check("t3_tmo_when", first, TMO + 1);
        check("t3_rdy_kept", {63'd0, cmd_rdy}, 64'd0);
        send_frame3(24'hAABBCC);
        step();
        check_out("t3", 24'hAABBCC, 1'b1, 1'b0);
        pulse_clr();

        // Overrun.
        send_frame3(24'h010203);
        step();
        check_out("t4a", 24'h010203, 1'b1, 1'b0);
        send_frame3(24'h040506);
        step();
        check_out("t4b", 24'h040506, 1'b1, 1'b1);
        pulse_clr();
        check_out("t4c", 24'h040506, 1'b0, 1'b0);

        // Completion and acknowledge on the same edge.
        send_frame3(24'h111111);
        step();
        send_frame3(24'h222222);
        clr_cmd_rdy = 1'b1;
        step();
        clr_cmd_rdy = 1'b0;
        check_out("t5", 24'h222222, 1'b1, 1'b0);
        pulse_clr();

`ifdef UART_CMD_CKSUM_EN
        // Checksum good, then bad.
        send_byte(8'h10, w); send_byte(8'h20, w); send_byte(8'h30, w); send_byte(8'h9F, w);
        step();
        check_out("t6a", 24'h102030, 1'b1, 1'b0);
        check("t6a_cerr", {63'd0, cksum_err}, 64'd0);
        pulse_clr();
        send_byte(8'h10, w); send_byte(8'h20, w); send_byte(8'h30, w); send_byte(8'h00, w);
        step();
        check("t6b_cerr", {63'd0, cksum_err}, 64'd1);
        check_out("t6b", 24'h102030, 1'b0, 1'b0);
        step();
        check("t6b_cerr_pulse", {63'd0, cksum_err}, 64'd0);
`endif

        // Reset mid-frame while acknowledging a byte.
        send_byte(8'hDE, w);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_out("t6r", 24'h0, 1'b0, 1'b0);
        check("t6r_clr", {63'd0, rx_rdy_clr}, 64'd0);
        check("t6r_tmo", {63'd0, tmo}, 64'd0);
        check("t6r_cerr", {63'd0, cksum_err}, 64'd0);
        send_frame3(24'h123456);
        step();
        check_out("t6r_after", 24'h123456, 1'b1, 1'b0);

        // Randomized traffic against the frame-level model.
        rst = 1'b1; step(); rst = 1'b0;
        fq.delete();
        m_cmd = '0; m_rdy = 1'b0; m_ovr = 1'b0; m_cerr = 1'b0;
        for (int it = 0; it < 150; it++) begin
            g = gaps[$urandom_range(0, 8)];
            tmo_cnt = 0;
            for (int j = 1; j <= g; j++) begin
                if (j >= 2 && $urandom_range(0, 7) == 0) begin
                    clr_cmd_rdy = 1'b1;
                    m_rdy = 1'b0;
                    m_ovr = 1'b0;
                end
                step();
                clr_cmd_rdy = 1'b0;
                if (tmo) tmo_cnt++;
                if (j == 1) begin
                    check_out("rnd", m_cmd, m_rdy, m_ovr);
                    check("rnd_cerr", {63'd0, cksum_err}, {63'd0, m_cerr});
                    check("rnd_clr_low", {63'd0, rx_rdy_clr}, 64'd0);
                end
            end
            check("rnd_tmo", tmo_cnt, (g > TMO && fq.size() > 0) ? 1 : 0);
            if (g > TMO) fq.delete();
            b = 8'($urandom);
`ifdef UART_CMD_CKSUM_EN
            if (fq.size() == NB && $urandom_range(0, 1) == 1) begin
                s = fq[0] + fq[1] + fq[2];
                b = ~s;
            end
`endif
            model_byte(b);
            send_byte(b, w);
            check("rnd_lat", w, 1);
        end
        step();
        check_out("rnd_final", m_cmd, m_rdy, m_ovr);
        check("rnd_final_cerr", {63'd0, cksum_err}, {63'd0, m_cerr});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
